// File: rtl/spi_pkg.sv
// Shared types and default widths for the SPI master shift engine.
package spi_pkg;

    localparam int SPI_DATA_W = 8;
    localparam int SPI_DIV_W  = 8;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_REQ   = 3'd1,
        ST_FETCH = 3'd2,
        ST_SHIFT = 3'd3,
        ST_DONE  = 3'd4
    } spi_state_t;

endpackage

// File: rtl/spi_clk_gen.sv
// SCLK half-period generator: toggles sclk every div+1 cycles while run is high
// and flags which toggle (rising or falling) happens on the coming clock edge.
module spi_clk_gen
    import spi_pkg::*;
#(
    parameter int DIV_W = SPI_DIV_W
) (
    input  logic             clk_i,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             run,
    input  logic [DIV_W-1:0] div,
    output logic             rise_stb,
    output logic             fall_stb,
    output logic             sclk
);

    logic [DIV_W-1:0] cnt_r;
    logic             sclk_r;
    logic             toggle_s;

    assign toggle_s = run && (cnt_r == div);
    assign rise_stb = toggle_s && !sclk_r;
    assign fall_stb = toggle_s && sclk_r;
    assign sclk     = sclk_r;

    // Half-period counter and SCLK level; parked low whenever not shifting.
    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            cnt_r  <= '0;
            sclk_r <= 1'b0;
        end else if (clr || !run) begin
            cnt_r  <= '0;
            sclk_r <= 1'b0;
        end else if (toggle_s) begin
            cnt_r  <= '0;
            sclk_r <= ~sclk_r;
        end else begin
            cnt_r  <= cnt_r + DIV_W'(1);
        end
    end

endmodule

// File: rtl/spi_tx_engine.sv
// SPI mode-0 master shift engine: pulls bytes from the TX FIFO, shifts them out
// on MOSI, captures MISO on SCLK rises and pushes received bytes to the RX FIFO.
module spi_tx_engine
    import spi_pkg::*;
#(
    parameter int DATA_W = SPI_DATA_W,
    parameter int DIV_W  = SPI_DIV_W
) (
    input  logic              clk_i,
    input  logic              rst_n,
    input  logic              en_i,
    input  logic [DIV_W-1:0]  clk_div_i,
    input  logic              lsb_first_i,
    input  logic              tx_empty_i,
    output logic              tx_r_en_o,
    input  logic [DATA_W-1:0] tx_data_i,
    input  logic              rx_full_i,
    output logic              rx_w_en_o,
    output logic [DATA_W-1:0] rx_data_o,
    output logic              sclk_o,
    output logic              mosi_o,
    input  logic              miso_i,
    output logic              cs_n_o,
    output logic              busy_o,
    output logic              rx_overrun_o,
    input  logic              clr_ovr_i
);

    localparam int CNT_W = $clog2(DATA_W + 1);

    spi_state_t        state_r;
    spi_state_t        next_state_s;
    logic [DATA_W-1:0] tx_shift_r;
    logic [DATA_W-1:0] tx_shift_next_s;
    logic [DATA_W-1:0] rx_shift_r;
    logic [DATA_W-1:0] rx_data_r;
    logic [DIV_W-1:0]  div_r;
    logic              lsb_r;
    logic [CNT_W-1:0]  bit_cnt_r;
    logic              cs_n_r;
    logic              mosi_r;
    logic              tx_r_en_r;
    logic              rx_w_en_r;
    logic              busy_r;
    logic              ovr_r;
    logic              rise_stb_s;
    logic              fall_stb_s;
    logic              sclk_s;
    logic              clr_s;
    logic              run_s;
    logic              start_s;
    logic              frame_end_s;
    logic              done_entry_s;

    function automatic logic lead_bit(input logic [DATA_W-1:0] data, input logic lsb);
        if (lsb) begin
            return data[0];
        end else begin
            return data[DATA_W-1];
        end
    endfunction

    assign clr_s        = (state_r == ST_FETCH);
    assign run_s        = (state_r == ST_SHIFT);
    assign start_s      = en_i && !tx_empty_i;
    assign frame_end_s  = fall_stb_s && (bit_cnt_r == CNT_W'(DATA_W - 1));
    assign done_entry_s = (state_r == ST_SHIFT) && frame_end_s;

    spi_clk_gen #(
        .DIV_W (DIV_W)
    ) u_clk_gen (
        .clk_i    (clk_i),
        .rst_n    (rst_n),
        .clr      (clr_s),
        .run      (run_s),
        .div      (div_r),
        .rise_stb (rise_stb_s),
        .fall_stb (fall_stb_s),
        .sclk     (sclk_s)
    );

    // State register.
    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Next-state decode; en_i only matters at frame boundaries.
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (start_s) begin
                    next_state_s = ST_REQ;
                end else begin
                    next_state_s = ST_IDLE;
                end
            end
            ST_REQ:   next_state_s = ST_FETCH;
            ST_FETCH: next_state_s = ST_SHIFT;
            ST_SHIFT: begin
                if (frame_end_s) begin
                    next_state_s = ST_DONE;
                end else begin
                    next_state_s = ST_SHIFT;
                end
            end
            ST_DONE: begin
                if (start_s) begin
                    next_state_s = ST_REQ;
                end else begin
                    next_state_s = ST_IDLE;
                end
            end
            default: next_state_s = ST_IDLE;
        endcase
    end

    // TX shift register after one more bit has gone out, in the latched order.
    always_comb begin
        tx_shift_next_s = tx_shift_r;
        if (lsb_r) begin
            tx_shift_next_s = tx_shift_r >> 1;
        end else begin
            tx_shift_next_s = tx_shift_r << 1;
        end
    end

    // Frame datapath: latch settings and data in FETCH, shift on SCLK edges.
    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            tx_shift_r <= '0;
            rx_shift_r <= '0;
            div_r      <= '0;
            lsb_r      <= 1'b0;
            bit_cnt_r  <= '0;
        end else if (state_r == ST_FETCH) begin
            tx_shift_r <= tx_data_i;
            rx_shift_r <= '0;
            div_r      <= clk_div_i;
            lsb_r      <= lsb_first_i;
            bit_cnt_r  <= '0;
        end else if (state_r == ST_SHIFT) begin
            if (fall_stb_s) begin
                tx_shift_r <= tx_shift_next_s;
                bit_cnt_r  <= bit_cnt_r + CNT_W'(1);
            end
            if (rise_stb_s) begin
                if (lsb_r) begin
                    rx_shift_r <= {miso_i, rx_shift_r[DATA_W-1:1]};
                end else begin
                    rx_shift_r <= {rx_shift_r[DATA_W-2:0], miso_i};
                end
            end
        end
    end

    // Registered pad-side outputs; CS stays low across back-to-back frames.
    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            cs_n_r <= 1'b1;
            mosi_r <= 1'b0;
            busy_r <= 1'b0;
        end else begin
            busy_r <= (next_state_s != ST_IDLE);
            if (next_state_s == ST_IDLE) begin
                cs_n_r <= 1'b1;
            end else if (next_state_s == ST_SHIFT) begin
                cs_n_r <= 1'b0;
            end
            if (next_state_s == ST_IDLE) begin
                mosi_r <= 1'b0;
            end else if (state_r == ST_FETCH) begin
                mosi_r <= lead_bit(tx_data_i, lsb_first_i);
            end else if (fall_stb_s && !frame_end_s) begin
                mosi_r <= lead_bit(tx_shift_next_s, lsb_r);
            end
        end
    end

    // FIFO strobes, received byte and sticky overrun (set beats clear).
    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            tx_r_en_r <= 1'b0;
            rx_w_en_r <= 1'b0;
            rx_data_r <= '0;
            ovr_r     <= 1'b0;
        end else begin
            tx_r_en_r <= (next_state_s == ST_REQ);
            rx_w_en_r <= done_entry_s && !rx_full_i;
            if (done_entry_s && !rx_full_i) begin
                rx_data_r <= rx_shift_r;
            end
            if (done_entry_s && rx_full_i) begin
                ovr_r <= 1'b1;
            end else if (clr_ovr_i) begin
                ovr_r <= 1'b0;
            end
        end
    end

    assign tx_r_en_o    = tx_r_en_r;
    assign rx_w_en_o    = rx_w_en_r;
    assign rx_data_o    = rx_data_r;
    assign sclk_o       = sclk_s;
    assign mosi_o       = mosi_r;
    assign cs_n_o       = cs_n_r;
    assign busy_o       = busy_r;
    assign rx_overrun_o = ovr_r;

endmodule

// File: tb/tb_spi_tx_engine.sv
// Self-checking bench for spi_tx_engine: a timeline model of the frame protocol
// drives per-cycle expectations, plus literal checks on captured waveforms.
module tb_spi_tx_engine;

    logic       clk_i       = 1'b0;
    logic       rst_n       = 1'b1;
    logic       en_i        = 1'b0;
    logic [7:0] clk_div_i   = 8'd1;
    logic       lsb_first_i = 1'b0;
    logic       tx_empty_i  = 1'b1;
    logic [7:0] tx_data_i   = 8'd0;
    logic       rx_full_i   = 1'b0;
    logic       clr_ovr_i   = 1'b0;
    logic       miso_i;
    logic       tx_r_en_o, rx_w_en_o, sclk_o, mosi_o, cs_n_o, busy_o, rx_overrun_o;
    logic [7:0] rx_data_o;

    logic       loop_en  = 1'b1;
    logic       miso_val = 1'b0;
    assign miso_i = loop_en ? mosi_o : miso_val;

    spi_tx_engine dut (
        .clk_i(clk_i), .rst_n(rst_n), .en_i(en_i), .clk_div_i(clk_div_i),
        .lsb_first_i(lsb_first_i), .tx_empty_i(tx_empty_i), .tx_r_en_o(tx_r_en_o),
        .tx_data_i(tx_data_i), .rx_full_i(rx_full_i), .rx_w_en_o(rx_w_en_o),
        .rx_data_o(rx_data_o), .sclk_o(sclk_o), .mosi_o(mosi_o), .miso_i(miso_i),
        .cs_n_o(cs_n_o), .busy_o(busy_o), .rx_overrun_o(rx_overrun_o),
        .clr_ovr_i(clr_ovr_i)
    );

    always #5 clk_i = ~clk_i;

    int         n_checks = 0;
    int         n_fail   = 0;
    logic       chk_en   = 1'b0;

    logic       exp_cs_n = 1'b1, exp_sclk = 1'b0, exp_mosi = 1'b0, exp_tx_r_en = 1'b0;
    logic       exp_rx_w_en = 1'b0, exp_busy = 1'b0, exp_ovr = 1'b0;
    logic [7:0] exp_rx_data = 8'd0;

    logic [7:0] tx_q[$];
    logic [7:0] rx_log[$];
    int         tx_pulses = 0;

    int         cyc = 0, rise_cnt = 0, last_rise = 0, rise_gap = 0, cs_low = 0;
    logic       prev_sclk = 1'b0;
    logic [7:0] mosi_bits = 8'd0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Timeline model: t counts cycles since the request was seen in idle/done.
    initial begin : model
        int         t, hm, s, b, pos;
        logic       act, req, set_o, lsbm;
        logic [7:0] dm, rxm;
        act = 1'b0; t = 0; hm = 1; lsbm = 1'b0; dm = 8'd0; rxm = 8'd0;
        forever begin
            @(posedge clk_i or negedge rst_n);
            if (!rst_n) begin
                act = 1'b0;
                exp_cs_n = 1'b1; exp_sclk = 1'b0; exp_mosi = 1'b0; exp_tx_r_en = 1'b0;
                exp_rx_w_en = 1'b0; exp_rx_data = 8'd0; exp_busy = 1'b0; exp_ovr = 1'b0;
            end else begin
                req = en_i && !tx_empty_i;
                set_o = 1'b0;
                exp_tx_r_en = 1'b0;
                exp_rx_w_en = 1'b0;
                if (act) begin
                    t++;
                end else if (req) begin
                    act = 1'b1; t = 1; exp_busy = 1'b1;
                end
                if (act) begin
                    if (t == 3) begin
                        hm = int'(clk_div_i) + 1; lsbm = lsb_first_i; dm = tx_data_i; rxm = 8'd0;
                    end
                    if (t == 1) begin
                        exp_tx_r_en = 1'b1;
                    end else if (t >= 3 && t < 3 + 16 * hm) begin
                        s = t - 3;
                        b = s / (2 * hm);
                        pos = lsbm ? b : 7 - b;
                        if (s % (2 * hm) == hm) rxm[pos] = loop_en ? exp_mosi : miso_val;
                        exp_sclk = ((s / hm) % 2) == 1;
                        exp_mosi = dm[pos];
                        exp_cs_n = 1'b0;
                    end else if (t == 3 + 16 * hm) begin
                        exp_sclk = 1'b0;
                        if (!rx_full_i) begin
                            exp_rx_w_en = 1'b1; exp_rx_data = rxm;
                        end else begin
                            set_o = 1'b1;
                        end
                    end else if (t == 4 + 16 * hm) begin
                        if (req) begin
                            t = 1; exp_tx_r_en = 1'b1;
                        end else begin
                            act = 1'b0; exp_cs_n = 1'b1; exp_mosi = 1'b0; exp_busy = 1'b0;
                        end
                    end
                end
                if (set_o) exp_ovr = 1'b1;
                else if (clr_ovr_i) exp_ovr = 1'b0;
            end
        end
    end

    // Per-cycle comparison against the model, away from the active edge.
    initial begin
        forever begin
            @(negedge clk_i);
            if (chk_en) begin
                chk("cs_n", cs_n_o, exp_cs_n);
                chk("sclk", sclk_o, exp_sclk);
                chk("mosi", mosi_o, exp_mosi);
                chk("tx_r_en", tx_r_en_o, exp_tx_r_en);
                chk("rx_w_en", rx_w_en_o, exp_rx_w_en);
                chk("busy", busy_o, exp_busy);
                chk("overrun", rx_overrun_o, exp_ovr);
                if (exp_rx_w_en) chk("rx_data", rx_data_o, exp_rx_data);
            end
        end
    end

    // FIFO emulation: data valid the cycle after the read strobe.
    initial begin
        forever begin
            @(posedge clk_i);
            if (tx_r_en_o) begin
                tx_pulses++;
                if (tx_q.size() > 0) tx_data_i <= tx_q.pop_front();
            end
            if (rx_w_en_o) rx_log.push_back(rx_data_o);
            tx_empty_i <= (tx_q.size() == 0);
        end
    end

    // Waveform monitor: MOSI at each SCLK rise, rise spacing, CS-low cycles.
    initial begin
        forever begin
            @(negedge clk_i);
            cyc++;
            if (sclk_o && !prev_sclk) begin
                rise_cnt++;
                mosi_bits = {mosi_bits[6:0], mosi_o};
                rise_gap = cyc - last_rise;
                last_rise = cyc;
            end
            prev_sclk = sclk_o;
            if (!cs_n_o) cs_low++;
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic cycles(input int n);
        repeat (n) @(negedge clk_i);
    endtask

    task automatic wait_idle(input string nm);
        cycles(4);
        for (int i = 0; i < 2000 && busy_o; i++) @(negedge clk_i);
        chk({nm, "_idle"}, busy_o, 1'b0);
    endtask

    task automatic wait_rises(input int base, input int n, input string nm);
        for (int i = 0; i < 2000 && (rise_cnt - base) < n; i++) @(negedge clk_i);
        chk({nm, "_rises"}, (rise_cnt - base) >= n, 1'b1);
    endtask

    int rb, tb, rxb, cb;

    initial begin
        #1 rst_n = 1'b0;
        #1 chk_en = 1'b1;
        cycles(3);
        chk("rst_cs_n", cs_n_o, 1'b1);
        chk("rst_busy", busy_o, 1'b0);
        chk("rst_rx_data", rx_data_o, 8'h00);
        rst_n = 1'b1;
        cycles(2);
        en_i = 1'b1;

        // Single byte MSB first, loopback, H=2
        rb = rise_cnt; rxb = rx_log.size();
        tx_q.push_back(8'hA5);
        wait_idle("t1");
        chk("t1_mosi_bits", mosi_bits, 8'hA5);
        chk("t1_rises", rise_cnt - rb, 8);
        chk("t1_sclk_period", rise_gap, 4);
        chk("t1_rx_count", rx_log.size() - rxb, 1);
        chk("t1_rx_byte", rx_log[$], 8'hA5);

        // LSB first, MISO tied high; divider change mid-frame is ignored
        loop_en = 1'b0; miso_val = 1'b1; lsb_first_i = 1'b1;
        rb = rise_cnt;
        tx_q.push_back(8'h01);
        wait_rises(rb, 1, "t2");
        clk_div_i = 8'd3;
        wait_idle("t2");
        chk("t2_mosi_bits", mosi_bits, 8'h80);
        chk("t2_sclk_period", rise_gap, 4);
        chk("t2_rx_byte", rx_log[$], 8'hFF);

        // Back-to-back at minimum divider
        loop_en = 1'b1; lsb_first_i = 1'b0; clk_div_i = 8'd0;
        rb = rise_cnt; tb = tx_pulses; rxb = rx_log.size(); cb = cs_low;
        tx_q.push_back(8'h3C); tx_q.push_back(8'hC3);
        wait_idle("t3");
        chk("t3_tx_pulses", tx_pulses - tb, 2);
        chk("t3_rises", rise_cnt - rb, 16);
        chk("t3_cs_low_cycles", cs_low - cb, 36);
        chk("t3_rx_count", rx_log.size() - rxb, 2);
        chk("t3_rx_first", rx_log[rxb], 8'h3C);
        chk("t3_rx_second", rx_log[rxb+1], 8'hC3);

        // RX full: overrun set, sticky, cleared, then set wins over clear
        rx_full_i = 1'b1;
        rxb = rx_log.size();
        tx_q.push_back(8'h55);
        wait_idle("t4a");
        chk("t4_no_rx_write", rx_log.size() - rxb, 0);
        chk("t4_ovr_set", rx_overrun_o, 1'b1);
        cycles(3);
        chk("t4_ovr_sticky", rx_overrun_o, 1'b1);
        clr_ovr_i = 1'b1;
        cycles(1);
        clr_ovr_i = 1'b0;
        chk("t4_ovr_cleared", rx_overrun_o, 1'b0);
        rb = rise_cnt;
        clr_ovr_i = 1'b1;
        tx_q.push_back(8'hAA);
        wait_rises(rb, 8, "t4b");
        for (int i = 0; i < 50 && sclk_o; i++) @(negedge clk_i);
        chk("t4_done_reached", sclk_o, 1'b0);
        clr_ovr_i = 1'b0;
        cycles(2);
        chk("t4_set_wins", rx_overrun_o, 1'b1);
        wait_idle("t4b");
        rx_full_i = 1'b0;

        // Enable dropped mid-frame with two bytes queued
        clk_div_i = 8'd1;
        rb = rise_cnt; tb = tx_pulses;
        tx_q.push_back(8'h11); tx_q.push_back(8'h22);
        wait_rises(rb, 3, "t5");
        en_i = 1'b0;
        wait_idle("t5");
        cycles(3);
        chk("t5_tx_pulses", tx_pulses - tb, 1);
        chk("t5_fifo_left", tx_q.size(), 1);
        chk("t5_rx_byte", rx_log[$], 8'h11);
        chk("t5_cs_n_idle", cs_n_o, 1'b1);
        tx_q.delete();
        cycles(3);
        en_i = 1'b1;
        cycles(2);

        // Reset in the middle of a frame
        rb = rise_cnt;
        tx_q.push_back(8'h77);
        wait_rises(rb, 5, "t6");
        #2 rst_n = 1'b0;
        #1;
        chk("t6_cs_n", cs_n_o, 1'b1);
        chk("t6_sclk", sclk_o, 1'b0);
        chk("t6_mosi", mosi_o, 1'b0);
        chk("t6_busy", busy_o, 1'b0);
        chk("t6_tx_r_en", tx_r_en_o, 1'b0);
        chk("t6_rx_w_en", rx_w_en_o, 1'b0);
        chk("t6_rx_data", rx_data_o, 8'h00);
        chk("t6_ovr", rx_overrun_o, 1'b0);
        tb = tx_pulses; rxb = rx_log.size();
        cycles(2);
        rst_n = 1'b1;
        cycles(40);
        chk("t6_no_tx_strobe", tx_pulses - tb, 0);
        chk("t6_no_rx_strobe", rx_log.size() - rxb, 0);

        chk_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
